mips_hazard_ctrl: RTL and testbench
===================================

Name: mips_hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core (IF/ID/EX/MEM/WB).
- Keeps a shadow pipeline of destination-register info for the EX, MEM and WB stages.
- Drives PC/IF-ID enables, IF-ID and ID-EX flushes, and the EX-stage operand forwarding selects.
- Sits beside the instruction decoder. It consumes the decoded write-register, load flag and pc_src_sel of the instruction currently in ID.

Parameters:
- REG_AW, 5, GPR address width.
- PCSRC_W, 3, width of pc_src_sel. Encodings come from the shared ctrl encode definitions: PCSRC_PLUS4, PCSRC_BT, PCSRC_JT, PCSRC_JR.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_AW  source register fields of the ID instruction.
- id_use_rs, id_use_rt  in  1  the ID instruction reads rs / rt.
- id_wr_en  in  1  the ID instruction writes a GPR (decoder gpr_w_sel is not XP).
- id_wr_reg  in  REG_AW  resolved destination register (rd, rt or 31).
- id_dm_r  in  1  the ID instruction is a load.
- id_pc_src  in  PCSRC_W  decoded pc_src_sel of the ID instruction.
- ex_redirect  in  1  EX resolved a taken branch, or a JR/JALR.
- mem_stall  in  1  data memory not ready; freeze the whole pipe.
- pc_en  out  1  PC register enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  load a bubble into IF/ID.
- idex_flush  out  1  load a bubble into ID/EX.
- fwd_a_sel, fwd_b_sel  out  2  EX operand source: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.

Behaviour:

Shadow state (flops):
- EX stage: ex_v, ex_wr, ex_reg, ex_ld, ex_rs, ex_rt, ex_use_rs, ex_use_rt.
- MEM stage: mem_wr, mem_reg.
- WB stage: wb_wr, wb_reg.

Reset:
- While rst_n is low, all shadow flops are 0.
- Outputs during reset: pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, fwd_*=00.

Hazard terms:
- A register index of 0 never matches any hazard.
- load_use = id_valid & ex_v & ex_ld & ex_wr & ex_reg != 0 & ((id_use_rs & id_rs == ex_reg) | (id_use_rt & id_rt == ex_reg)).
- id_jump = id_valid & id_pc_src == PCSRC_JT.

Output priority, combinational, highest first:
1. mem_stall: pc_en=0, ifid_en=0, no flushes, shadow holds.
2. ex_redirect: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1.
3. load_use: pc_en=0, ifid_en=0, idex_flush=1. This gives exactly 1 bubble.
4. id_jump: pc_en=1, ifid_flush=1. This gives a 1-cycle penalty.
5. Otherwise: pc_en=1, ifid_en=1, no flushes.

Shadow advance, each edge when mem_stall=0:
- WB fields <= MEM fields; MEM fields <= EX fields.
- EX fields <= ID inputs, or <= 0 (bubble) when idex_flush=1 or id_valid=0.

Forwarding (combinational from shadow state):
- fwd_a_sel=01 if ex_use_rs & mem_wr & mem_reg != 0 & mem_reg == ex_rs.
- Else fwd_a_sel=10 if the same condition holds for the WB fields.
- Else fwd_a_sel=00.
- EX/MEM takes priority over MEM/WB. fwd_b_sel is identical using rt.

Boundary rules:
- The register file is write-before-read, so there is no WB-to-ID hazard.
- ex_redirect with a simultaneous load_use: the redirect wins and no stall is taken.
- mem_stall overrides everything and does not lose a pending load_use; it is re-evaluated after the freeze.
- Branch (PCSRC_BT) and JR (PCSRC_JR) in ID cause no action until EX asserts ex_redirect.

Latency:
- Enables and flushes are combinational from the inputs and shadow state in the same cycle.
- Shadow state lags the ID instruction by one cycle per stage.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds 32-bit output ports stall_cnt and flush_cnt, both reset to 0 and wrapping at 2^32.
  - stall_cnt increments on each edge with load_use active and no higher-priority term.
  - flush_cnt increments on each edge with ex_redirect or id_jump effective and mem_stall=0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/include: PCSRC_* encodings, FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, REG_AW.
- Sub-module hazard_fwd_unit: purely the forwarding comparator. Instantiate it twice, once for operand A and once for operand B.
- Shadow pipeline and priority logic stay in mips_hazard_ctrl.

Test Plan:
1. lw $2 then add $3,$2,$4 back-to-back -> cycle 2: pc_en=0, ifid_en=0, idex_flush=1 for one cycle; next cycle fwd_a_sel=10.
2. add $5,$1,$1 then sub $6,$5,$5 -> when sub is in EX, fwd_a_sel=01 and fwd_b_sel=01; no stall.
3. Writes to $0 followed by a reader of $0 -> fwd_*=00 and no load_use stall.
4. ex_redirect=1 together with load_use=1 -> ifid_flush=1, idex_flush=1, pc_en=1.
5. j in ID -> ifid_flush=1 for exactly 1 cycle. mem_stall held for 3 cycles mid-sequence -> pc_en=0 for 3 cycles and shadow values unchanged.
6. Assert rst_n low mid-stream -> shadow state clears asynchronously and outputs go to reset values. With HAZARD_PERF_CNT_EN, stall_cnt=1 after scenario 1.

Source files
------------

// File: rtl/mips_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_hazard_ctrl_pkg
//   Shared definitions for the 5-stage MIPS hazard controller:
//   - REG_AW  : GPR address width
//   - PCSRC_* : pc_src_sel encodings produced by the instruction decoder
//   - FWD_*   : EX-stage operand forwarding selects
// -----------------------------------------------------------------------------
package mips_hazard_ctrl_pkg;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned PCSRC_W = 3;

  // pc_src_sel encodings (shared with the decoder)
  localparam logic [PCSRC_W-1:0] PCSRC_PLUS4 = 3'd0;
  localparam logic [PCSRC_W-1:0] PCSRC_BT    = 3'd1;
  localparam logic [PCSRC_W-1:0] PCSRC_JT    = 3'd2;
  localparam logic [PCSRC_W-1:0] PCSRC_JR    = 3'd3;

  // EX operand source selects
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage : mips_hazard_ctrl_pkg

// File: rtl/mips_hazard_ctrl_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
//   Forwarding comparator for one EX-stage source operand. Picks the youngest
//   in-flight producer of the operand's register; $0 never forwards.
//
// Ports:
//   ex_use_i  : the EX instruction reads this operand
//   ex_src_i  : source register index of the operand
//   mem_wr_i  : EX/MEM instruction writes a GPR
//   mem_reg_i : EX/MEM destination register
//   wb_wr_i   : MEM/WB instruction writes a GPR
//   wb_reg_i  : MEM/WB destination register
//   fwd_sel_o : FWD_RF / FWD_EXMEM / FWD_MEMWB
// -----------------------------------------------------------------------------
module hazard_fwd_unit #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              ex_use_i,
  input  logic [REG_AW-1:0] ex_src_i,
  input  logic              mem_wr_i,
  input  logic [REG_AW-1:0] mem_reg_i,
  input  logic              wb_wr_i,
  input  logic [REG_AW-1:0] wb_reg_i,
  output logic [1:0]        fwd_sel_o
);

  import mips_hazard_ctrl_pkg::*;

  logic hit_mem;
  logic hit_wb;

  assign hit_mem = ex_use_i & mem_wr_i & (mem_reg_i != '0) & (mem_reg_i == ex_src_i);
  assign hit_wb  = ex_use_i & wb_wr_i  & (wb_reg_i  != '0) & (wb_reg_i  == ex_src_i);

  // EX/MEM holds the younger value, so it wins over MEM/WB.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
    fwd_sel_o = FWD_RF;
    if (hit_mem)     fwd_sel_o = FWD_EXMEM;
    else if (hit_wb) fwd_sel_o = FWD_MEMWB;
  end

endmodule : hazard_fwd_unit

// File: rtl/mips_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// mips_hazard_ctrl
//   Hazard controller for the 5-stage MIPS core. Tracks destination-register
//   info of the EX/MEM/WB stages in a shadow pipeline, resolves stalls and
//   flushes by fixed priority, and drives the EX operand forwarding selects.
//
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   id_valid                : ID holds a real instruction
//   id_rs/id_rt             : ID source registers, id_use_rs/id_use_rt qualify them
//   id_wr_en/id_wr_reg      : ID writes a GPR / its destination
//   id_dm_r                 : ID instruction is a load
//   id_pc_src               : decoded pc_src_sel of the ID instruction
//   ex_redirect             : EX resolved a taken branch or JR/JALR
//   mem_stall               : data memory not ready, freeze everything
//   pc_en, ifid_en          : PC and IF/ID enables
//   ifid_flush, idex_flush  : bubble insertion into IF/ID and ID/EX
//   fwd_a_sel, fwd_b_sel    : EX operand sources (00 RF, 01 EX/MEM, 10 MEM/WB)
//
// Optional build macro HAZARD_PERF_CNT_EN adds stall_cnt / flush_cnt
// (32-bit wrapping event counters).
// -----------------------------------------------------------------------------
module mips_hazard_ctrl #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned PCSRC_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic               id_use_rs,
  input  logic               id_use_rt,
  input  logic               id_wr_en,
  input  logic [REG_AW-1:0]  id_wr_reg,
  input  logic               id_dm_r,
  input  logic [PCSRC_W-1:0] id_pc_src,
  input  logic               ex_redirect,
  input  logic               mem_stall,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic [1:0]         fwd_a_sel,
  output logic [1:0]         fwd_b_sel
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  import mips_hazard_ctrl_pkg::*;

  // ---------------------------------------------------------------------------
  // Shadow pipeline
  // ---------------------------------------------------------------------------
  logic              ex_v_q, ex_wr_q, ex_ld_q, ex_use_rs_q, ex_use_rt_q;
  logic [REG_AW-1:0] ex_reg_q, ex_rs_q, ex_rt_q;
  logic              mem_wr_q, wb_wr_q;
  logic [REG_AW-1:0] mem_reg_q, wb_reg_q;

  logic load_use;
  logic id_jump;
  logic ex_bubble;

  assign load_use = id_valid & ex_v_q & ex_ld_q & ex_wr_q & (ex_reg_q != '0)
                  & ((id_use_rs & (id_rs == ex_reg_q)) | (id_use_rt & (id_rt == ex_reg_q)));
  assign id_jump  = id_valid & (id_pc_src == PCSRC_JT);

  // ---------------------------------------------------------------------------
  // Priority logic: mem_stall > ex_redirect > load_use > id_jump > run.
  // Reset forces the "everything flushed, nothing fetched" state.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!rst_n) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (mem_stall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
    end else if (ex_redirect) begin
      // A simultaneous load_use is moot: its consumer is being squashed.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end
  end

  assign ex_bubble = idex_flush | ~id_valid;

  // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of its predecessor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_q      <= 1'b0;
      ex_wr_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      ex_use_rs_q <= 1'b0;
      ex_use_rt_q <= 1'b0;
      ex_reg_q    <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      mem_wr_q    <= 1'b0;
      mem_reg_q   <= '0;
      wb_wr_q     <= 1'b0;
      wb_reg_q    <= '0;
    end else if (!mem_stall) begin
      wb_wr_q   <= mem_wr_q;
      wb_reg_q  <= mem_reg_q;
      mem_wr_q  <= ex_wr_q;
      mem_reg_q <= ex_reg_q;
      if (ex_bubble) begin
        ex_v_q      <= 1'b0;
        ex_wr_q     <= 1'b0;
        ex_ld_q     <= 1'b0;
        ex_use_rs_q <= 1'b0;
        ex_use_rt_q <= 1'b0;
        ex_reg_q    <= '0;
        ex_rs_q     <= '0;
        ex_rt_q     <= '0;
      end else begin
        ex_v_q      <= 1'b1;
        ex_wr_q     <= id_wr_en;
        ex_ld_q     <= id_dm_r;
        ex_use_rs_q <= id_use_rs;
        ex_use_rt_q <= id_use_rt;
        ex_reg_q    <= id_wr_reg;
        ex_rs_q     <= id_rs;
        ex_rt_q     <= id_rt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .ex_use_i  (ex_use_rs_q),
    .ex_src_i  (ex_rs_q),
    .mem_wr_i  (mem_wr_q),
    .mem_reg_i (mem_reg_q),
    .wb_wr_i   (wb_wr_q),
    .wb_reg_i  (wb_reg_q),
    .fwd_sel_o (fwd_a_sel)
  );

  hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .ex_use_i  (ex_use_rt_q),
    .ex_src_i  (ex_rt_q),
    .mem_wr_i  (mem_wr_q),
    .mem_reg_i (mem_reg_q),
    .wb_wr_i   (wb_wr_q),
    .wb_reg_i  (wb_reg_q),
    .fwd_sel_o (fwd_b_sel)
  );

`ifdef HAZARD_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  logic stall_evt;
  logic flush_evt;

  // ifid_flush outside mem_stall is exactly "redirect or jump took effect".
  assign stall_evt = load_use & ~mem_stall & ~ex_redirect;
  assign flush_evt = ifid_flush & ~mem_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt) stall_cnt <= stall_cnt + 32'd1;
      if (flush_evt) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule : mips_hazard_ctrl

// File: tb/tb_mips_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_hazard_ctrl
//   Directed-vector bench for mips_hazard_ctrl. Inputs change 1 ns after the
//   rising edge; outputs are sampled 2 ns after it.
// -----------------------------------------------------------------------------
module tb_mips_hazard_ctrl;

  import mips_hazard_ctrl_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               id_valid;
  logic [REG_AW-1:0]  id_rs, id_rt, id_wr_reg;
  logic               id_use_rs, id_use_rt, id_wr_en, id_dm_r;
  logic [PCSRC_W-1:0] id_pc_src;
  logic               ex_redirect, mem_stall;
  logic               pc_en, ifid_en, ifid_flush, idex_flush;
  logic [1:0]         fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]        stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_hazard_ctrl #(.REG_AW(REG_AW), .PCSRC_W(PCSRC_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_wr_en    (id_wr_en),
    .id_wr_reg   (id_wr_reg),
    .id_dm_r     (id_dm_r),
    .id_pc_src   (id_pc_src),
    .ex_redirect (ex_redirect),
    .mem_stall   (mem_stall),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {pc_en, ifid_en, ifid_flush, idex_flush}
  task automatic check_ctl(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, pc_en, ifid_en, ifid_flush, idex_flush}, {28'd0, exp});
  endtask

  task automatic check_fwd(input string tag, input logic [1:0] exp_a, input logic [1:0] exp_b);
    check(tag, {28'd0, fwd_a_sel, fwd_b_sel}, {28'd0, exp_a, exp_b});
  endtask

  task automatic set_id(input logic v, input int rs, input int rt, input logic urs,
                        input logic urt, input logic wr, input int wreg, input logic ld,
                        input logic [PCSRC_W-1:0] src);
    id_valid  = v;
    id_rs     = REG_AW'(rs);
    id_rt     = REG_AW'(rt);
    id_use_rs = urs;
    id_use_rt = urt;
    id_wr_en  = wr;
    id_wr_reg = REG_AW'(wreg);
    id_dm_r   = ld;
    id_pc_src = src;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    ex_redirect = 1'b0;
    mem_stall   = 1'b0;
    set_id(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, PCSRC_PLUS4);
    #12;
    check_ctl("reset_ctl", 4'b0011);
    check_fwd("reset_fwd", 2'b00, 2'b00);
    rst_n = 1'b1;
    tick();

    // 1: lw $2,0($1) ; add $3,$2,$4
    set_id(1'b1, 1, 2, 1'b1, 1'b0, 1'b1, 2, 1'b1, PCSRC_PLUS4);
    settle();
    check_ctl("lw_in_id_run", 4'b1100);
    tick();
    set_id(1'b1, 2, 4, 1'b1, 1'b1, 1'b1, 3, 1'b0, PCSRC_PLUS4);
    settle();
    check_ctl("load_use_stall", 4'b0001);
    tick();
    settle();
    check_ctl("load_use_one_bubble", 4'b1100);
    check_fwd("bubble_in_ex_fwd", 2'b00, 2'b00);
    tick();
    // 2: add $3 in EX, lw in WB -> A from MEM/WB. Next: add $5,$1,$1
    check_fwd("load_use_fwd_memwb", 2'b10, 2'b00);
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt_after_s1", stall_cnt, 32'd1);
`endif
    set_id(1'b1, 1, 1, 1'b1, 1'b1, 1'b1, 5, 1'b0, PCSRC_PLUS4);
    tick();
    set_id(1'b1, 5, 5, 1'b1, 1'b1, 1'b1, 6, 1'b0, PCSRC_PLUS4);
    settle();
    check_ctl("alu_dep_no_stall", 4'b1100);
    tick();
    check_fwd("exmem_fwd_both", 2'b01, 2'b01);
    // or $7,$5,$6 : $5 now in WB, $6 in MEM
    set_id(1'b1, 5, 6, 1'b1, 1'b1, 1'b1, 7, 1'b0, PCSRC_PLUS4);
    tick();
    check_fwd("mixed_fwd", 2'b10, 2'b01);

    // 3: lw $0 ; add $8,$0,$0
    set_id(1'b1, 1, 0, 1'b1, 1'b0, 1'b1, 0, 1'b1, PCSRC_PLUS4);
    tick();
    set_id(1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 8, 1'b0, PCSRC_PLUS4);
    settle();
    check_ctl("r0_no_load_use", 4'b1100);
    tick();
    check_fwd("r0_no_fwd", 2'b00, 2'b00);

    // 4: lw $9 then a reader while EX redirects
    set_id(1'b1, 1, 9, 1'b1, 1'b0, 1'b1, 9, 1'b1, PCSRC_PLUS4);
    tick();
    set_id(1'b1, 9, 9, 1'b1, 1'b1, 1'b1, 10, 1'b0, PCSRC_PLUS4);
    ex_redirect = 1'b1;
    settle();
    check_ctl("redirect_beats_load_use", 4'b1111);
    tick();
    ex_redirect = 1'b0;
    set_id(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, PCSRC_PLUS4);
    settle();
    check_ctl("after_redirect_run", 4'b1100);

    // 5: j, then bubble, then beq (no action)
    set_id(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, PCSRC_JT);
    settle();
    check_ctl("jump_flush", 4'b1110);
    tick();
    set_id(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, PCSRC_PLUS4);
    settle();
    check_ctl("jump_one_cycle", 4'b1100);
`ifdef HAZARD_PERF_CNT_EN
    check("flush_cnt_after_jump", flush_cnt, 32'd2);
`endif
    set_id(1'b1, 1, 2, 1'b1, 1'b1, 1'b0, 0, 1'b0, PCSRC_BT);
    settle();
    check_ctl("branch_no_action", 4'b1100);
    set_id(1'b1, 31, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, PCSRC_JR);
    settle();
    check_ctl("jr_no_action", 4'b1100);
    tick();

    // mem_stall freeze with a pending load_use
    set_id(1'b1, 11, 12, 1'b1, 1'b1, 1'b1, 10, 1'b0, PCSRC_PLUS4); // add $10
    tick();
    set_id(1'b1, 10, 13, 1'b1, 1'b0, 1'b1, 13, 1'b1, PCSRC_PLUS4); // lw $13,0($10)
    tick();
    check_fwd("pre_stall_fwd", 2'b01, 2'b00);
    set_id(1'b1, 13, 0, 1'b1, 1'b0, 1'b1, 14, 1'b0, PCSRC_PLUS4);  // add $14,$13,$0
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_ctl($sformatf("mem_stall_ctl_%0d", i), 4'b0000);
      check_fwd($sformatf("mem_stall_hold_%0d", i), 2'b01, 2'b00);
      tick();
    end
    mem_stall = 1'b0;
    settle();
    check_ctl("load_use_after_freeze", 4'b0001);
    tick();
    settle();
    check_ctl("after_freeze_bubble", 4'b1100);
    tick();
    check_fwd("after_freeze_fwd", 2'b10, 2'b00);
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt_after_freeze", stall_cnt, 32'd2);
`endif

    // 6: asynchronous reset mid-stream
    rst_n = 1'b0;
    settle();
    check_ctl("async_reset_ctl", 4'b0011);
    check_fwd("async_reset_fwd", 2'b00, 2'b00);
`ifdef HAZARD_PERF_CNT_EN
    check("async_reset_cnt", stall_cnt | flush_cnt, 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    set_id(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, PCSRC_PLUS4);
    settle();
    check_ctl("post_reset_run", 4'b1100);
    check_fwd("post_reset_fwd", 2'b00, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mips_hazard_ctrl
